// File: rtl/sop_truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// The popcount/first-set helpers serve the SWEEP_FAIL_DIAG_EN build.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VEC = 16;

    // Minterms 2,3,4,5,A,B,D,F of f(a,b,c,d).
    localparam logic [15:0] SOP_2345ABDF_MASK = 16'hAC3C;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] first_set16(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sop_truth_table_sweeper_settle_timer.sv
// Per-vector settle timer: counts 0..SETTLE while enabled, flags the
// final count with 'last' and wraps to 0 on the cycle after it.
module sweep_settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic last
);

    // The counter is 4 bits wide, so a longer settle cannot be represented.
    if (SETTLE > 15) begin : g_settle_range
        $error("sweep_settle_timer: SETTLE must be in 0..15");
    end

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [3:0] cnt_q, cnt_d;

    assign last = (cnt_q == SETTLE_C);

    // Next count: clear wins, otherwise advance and wrap on the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sop_truth_table_sweeper.sv
// Clocked stimulus/capture sweep around a 4-input combinational function.
// Drives vectors 0..15 on abcd_out, samples s_in for each after SETTLE
// extra cycles, and compares the captured table against EXPECTED.
// Optional macro SWEEP_FAIL_DIAG_EN adds first_fail_idx and fail_count.
//
// state | meaning
// IDLE  | waiting for start; table_out/pass hold the last result
// SWEEP | presenting vector idx, sampling s_in when the settle timer ends
// DONE  | one-cycle completion pulse, then back to IDLE
module sop_truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter logic [15:0] EXPECTED = SOP_2345ABDF_MASK,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_in,
    output logic [3:0]  abcd_out,
    output logic [15:0] table_out,
    output logic        busy,
    output logic        done,
    output logic        pass
`ifdef SWEEP_FAIL_DIAG_EN
    ,
    output logic [3:0]  first_fail_idx,
    output logic [4:0]  fail_count
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] table_q, table_d;
    logic        pass_q, pass_d;
    logic        timer_clr, timer_en, timer_last;

`ifdef SWEEP_FAIL_DIAG_EN
    logic [3:0]  ffi_q, ffi_d;
    logic [4:0]  fcnt_q, fcnt_d;
`endif

    sweep_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clr),
        .en    (timer_en),
        .last  (timer_last)
    );

    // Next-state, capture and result logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        table_d   = table_q;
        pass_d    = pass_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
`ifdef SWEEP_FAIL_DIAG_EN
        ffi_d     = ffi_q;
        fcnt_d    = fcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SWEEP;
                    idx_d     = '0;
                    table_d   = '0;
                    pass_d    = 1'b0;
                    timer_clr = 1'b1;
`ifdef SWEEP_FAIL_DIAG_EN
                    ffi_d     = '0;
                    fcnt_d    = '0;
`endif
                end
            end
            SWEEP: begin
                timer_en = 1'b1;
                if (timer_last) begin
                    table_d[idx_q] = s_in;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        pass_d  = (table_d == EXPECTED);
`ifdef SWEEP_FAIL_DIAG_EN
                        ffi_d   = first_set16(table_d ^ EXPECTED);
                        fcnt_d  = popcount16(table_d ^ EXPECTED);
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
`ifdef SWEEP_FAIL_DIAG_EN
            ffi_q   <= '0;
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            pass_q  <= pass_d;
`ifdef SWEEP_FAIL_DIAG_EN
            ffi_q   <= ffi_d;
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign abcd_out  = idx_q;
    assign table_out = table_q;
    assign pass      = pass_q;
    assign busy      = (state_q == SWEEP);
    assign done      = (state_q == DONE);

`ifdef SWEEP_FAIL_DIAG_EN
    assign first_fail_idx = ffi_q;
    assign fail_count     = fcnt_q;
`endif

endmodule

// File: tb/tb_sop_truth_table_sweeper.sv
// Bench for sop_truth_table_sweeper: one instance with SETTLE=1 and one
// with SETTLE=0, each fed by a behavioural function model on s_in.
module tb_sop_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset     = 1'b1;
    logic start_req = 1'b0;
    bit   sel       = 1'b0;   // 0: SETTLE=1 instance, 1: SETTLE=0 instance
    int   mode      = 0;      // 0: SoP(2,3,4,5,A,B,D,F), 1: tied 0, 2: SoP without F

    logic        start1, start0, s_in1, s_in0;
    logic [3:0]  abcd1, abcd0;
    logic [15:0] tbl1, tbl0;
    logic        busy1, busy0, done1, done0, pass1, pass0;
`ifdef SWEEP_FAIL_DIAG_EN
    logic [3:0]  ffi1, ffi0;
    logic [4:0]  fc1, fc0;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        p;
        logic [3:0]  ffi;
        logic [4:0]  fc;
    } exp_t;
    exp_t sb[$];

    function automatic logic fmodel(input logic [3:0] v, input int m);
        logic hit;
        hit = (v == 4'h2) || (v == 4'h3) || (v == 4'h4) || (v == 4'h5) ||
              (v == 4'hA) || (v == 4'hB) || (v == 4'hD) || (v == 4'hF);
        case (m)
            0:       return hit;
            2:       return hit && (v != 4'hF);
            default: return 1'b0;
        endcase
    endfunction

    assign start1 = start_req & ~sel;
    assign start0 = start_req & sel;
    assign s_in1  = fmodel(abcd1, mode);
    assign s_in0  = fmodel(abcd0, mode);

    sop_truth_table_sweeper #(.EXPECTED(16'hAC3C), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start1), .s_in(s_in1),
        .abcd_out(abcd1), .table_out(tbl1), .busy(busy1), .done(done1),
        .pass(pass1)
`ifdef SWEEP_FAIL_DIAG_EN
        , .first_fail_idx(ffi1), .fail_count(fc1)
`endif
    );

    sop_truth_table_sweeper #(.EXPECTED(16'hAC3C), .SETTLE(0)) u_s0 (
        .clk(clk), .reset(reset), .start(start0), .s_in(s_in0),
        .abcd_out(abcd0), .table_out(tbl0), .busy(busy0), .done(done0),
        .pass(pass0)
`ifdef SWEEP_FAIL_DIAG_EN
        , .first_fail_idx(ffi0), .fail_count(fc0)
`endif
    );

    // Views of the selected instance.
    logic [3:0]  v_abcd;
    logic [15:0] v_tbl;
    logic        v_busy, v_done, v_pass;
    assign v_abcd = sel ? abcd0 : abcd1;
    assign v_tbl  = sel ? tbl0  : tbl1;
    assign v_busy = sel ? busy0 : busy1;
    assign v_done = sel ? done0 : done1;
    assign v_pass = sel ? pass0 : pass1;
`ifdef SWEEP_FAIL_DIAG_EN
    logic [3:0] v_ffi;
    logic [4:0] v_fc;
    assign v_ffi = sel ? ffi0 : ffi1;
    assign v_fc  = sel ? fc0  : fc1;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, " abcd"}, 32'(v_abcd), 32'd0);
        chk({tag, " table"}, 32'(v_tbl), 32'd0);
        chk({tag, " busy"}, 32'(v_busy), 32'd0);
        chk({tag, " done"}, 32'(v_done), 32'd0);
        chk({tag, " pass"}, 32'(v_pass), 32'd0);
`ifdef SWEEP_FAIL_DIAG_EN
        chk({tag, " ffi"}, 32'(v_ffi), 32'd0);
        chk({tag, " fcnt"}, 32'(v_fc), 32'd0);
`endif
    endtask

    // One full sweep on the selected instance; the expected result is
    // queued at start and popped when done is observed.
    task automatic do_sweep(input bit s, input int m, input logic [15:0] et,
                            input logic ep, input logic [3:0] eff,
                            input logic [4:0] efc, input bit inject,
                            input string tag);
        int   t, per, busy_cnt;
        bit   step_ok;
        exp_t e;
        sel  = s;
        mode = m;
        per  = s ? 1 : 2;
        @(negedge clk);
        start_req = 1'b1;
        e.tbl = et; e.p = ep; e.ffi = eff; e.fc = efc;
        sb.push_back(e);
        @(negedge clk);
        start_req = 1'b0;
        t = 0; busy_cnt = 0; step_ok = 1'b1;
        while (!v_done && t < 200) begin
            if (v_busy) busy_cnt++;
            if (v_abcd !== 4'(t / per)) step_ok = 1'b0;
            start_req = (inject && (t == 10 || t == 23)) ? 1'b1 : 1'b0;
            @(negedge clk);
            t++;
        end
        start_req = 1'b0;
        chk({tag, " latency"}, 32'(t), 32'(16 * per));
        chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(16 * per));
        chk({tag, " abcd stepping"}, 32'(step_ok), 32'd1);
        chk({tag, " busy at done"}, 32'(v_busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, " table"}, 32'(v_tbl), 32'(e.tbl));
            chk({tag, " pass"}, 32'(v_pass), 32'(e.p));
`ifdef SWEEP_FAIL_DIAG_EN
            chk({tag, " ffi"}, 32'(v_ffi), 32'(e.ffi));
            chk({tag, " fcnt"}, 32'(v_fc), 32'(e.fc));
`endif
        end
        if (inject) start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk({tag, " done pulse width"}, 32'(v_done), 32'd0);
        chk({tag, " abcd back to 0"}, 32'(v_abcd), 32'd0);
        chk({tag, " busy idle"}, 32'(v_busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, " no restart"}, 32'(v_busy), 32'd0);
        chk({tag, " table hold"}, 32'(v_tbl), 32'(et));
        chk({tag, " pass hold"}, 32'(v_pass), 32'(ep));
    endtask

    initial begin
        int  n;
        // Reset values on both instances.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0; #0 check_idle_zero("reset s1");
        sel = 1'b1; #0 check_idle_zero("reset s0");
        reset = 1'b0;
        @(negedge clk);

        do_sweep(1'b0, 0, 16'hAC3C, 1'b1, 4'd0,  5'd0, 1'b0, "t1 sop");
        do_sweep(1'b0, 1, 16'h0000, 1'b0, 4'd2,  5'd8, 1'b0, "t2 zero");
        do_sweep(1'b0, 2, 16'h2C3C, 1'b0, 4'd15, 5'd1, 1'b0, "t3 noF");
        do_sweep(1'b0, 0, 16'hAC3C, 1'b1, 4'd0,  5'd0, 1'b1, "t4 extra start");

        // Reset in the middle of a sweep, at vector 7.
        sel  = 1'b0;
        mode = 0;
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        n = 0;
        while (v_abcd !== 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached vec7", 32'(v_abcd), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_zero("t5 after reset");
        @(negedge clk);
        chk("t5 stays idle", 32'(v_busy), 32'd0);
        do_sweep(1'b0, 0, 16'hAC3C, 1'b1, 4'd0, 5'd0, 1'b0, "t5 resweep");

        do_sweep(1'b1, 0, 16'hAC3C, 1'b1, 4'd0,  5'd0, 1'b0, "t6 settle0");
        do_sweep(1'b1, 2, 16'h2C3C, 1'b0, 4'd15, 5'd1, 1'b0, "t6 settle0 noF");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sop_truth_table_sweeper.md
Name: sop_truth_table_sweeper

Overview:
Sequential stimulus-and-capture stage wrapped around a 4-input combinational function block (e.g. the SoP(2,3,4,5,A,B,D,F) unit).
- Upstream side: drives vectors 0..15 onto a,b,c,d.
- Downstream side: samples the function output for each vector and assembles a 16-bit truth table.
- Compares the table against an expected minterm mask and reports pass/fail.
- Replaces hand-written 16-step stimulus sequences with a clocked, self-checking sweep.

Parameters:
- EXPECTED, 16'hAC3C, expected truth table; bit i = f(i), i = {a,b,c,d}.
- SETTLE, 1, extra hold cycles per vector before sampling. Range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- s_in  input  1  output of the function under test.
- abcd_out  output  4  vector to the function: bit3=a, bit2=b, bit1=c, bit0=d.
- table_out  output  16  captured truth table; bit i = s_in sampled for vector i.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  table_out == EXPECTED; valid from done until the next accepted start.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, abcd_out=0, table_out=0, busy=0, done=0, pass=0, idx=0, wait counter=0.
- FSM states:
  - IDLE → SWEEP when start=1. On that edge: idx=0, wait=0, table_out=0, pass=0, busy=1.
  - SWEEP: abcd_out = idx, registered and stable for SETTLE+1 cycles. wait counts 0..SETTLE.
  - SWEEP, when wait==SETTLE: table_out[idx] <= s_in on that edge.
  - SWEEP, idx<15: idx <= idx+1 and wait <= 0.
  - SWEEP, idx==15: go to DONE; pass <= (updated table == EXPECTED).
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. abcd_out returns to 0 on entry to IDLE.
- Latency: done is high in the cycle after the 16*(SETTLE+1)-th rising edge following the edge that sampled start.
- s_in is treated as combinational from abcd_out, so SETTLE=0 samples in the same cycle the vector is presented.
- start is ignored while in SWEEP or DONE. It has no queueing or restart effect.
- table_out and pass hold their values in IDLE until the next accepted start.
- Reset mid-sweep wins over everything: all outputs reach reset values at that edge, and any partial table is discarded.
- Width rules:
  - idx is 4 bits and never wraps past 15 within a sweep.
  - The wait counter is 4 bits; SETTLE > 15 is illegal and must be flagged by an elaboration-time check.
- s_in is treated as 2-state; X/Z handling is out of scope for the RTL.

Optional Feature:
Macro: SWEEP_FAIL_DIAG_EN.
- Defined: adds outputs first_fail_idx[3:0] and fail_count[4:0].
  - first_fail_idx = lowest i where table_out[i] != EXPECTED[i].
  - fail_count = popcount(table_out ^ EXPECTED), range 0..16.
  - Both update on the same edge as pass. Both are cleared on reset and on an accepted start.
  - When pass=1: first_fail_idx=0 and fail_count=0.
- Undefined: neither port nor its logic exists; the core behaviour is unchanged.

Decomposition:
- Package sweep_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - NUM_VEC=16;
  - constant SOP_2345ABDF_MASK=16'hAC3C, used as the EXPECTED default;
  - a popcount16 function for the diag option.
- Natural sub-module: sweep_settle_timer, the SETTLE wait counter with a "last" flag.
- The FSM and capture register stay in the top module.

Test Plan:
1. Reset, SETTLE=1, s_in from the SoP(2,3,4,5,A,B,D,F) function, start pulse → abcd_out steps 0..15, each held 2 cycles; done at the 32nd edge after start; table_out=16'hAC3C, pass=1.
2. s_in tied 0 → table_out=16'h0000, pass=0; with SWEEP_FAIL_DIAG_EN: first_fail_idx=2, fail_count=8.
3. Function with minterm F removed → table_out=16'h2C3C, pass=0; diag: first_fail_idx=15, fail_count=1.
4. Extra start pulses during SWEEP and in the done cycle → ignored; exactly one sweep; busy stays high for exactly 32 cycles.
5. Reset asserted while abcd_out=7 → next cycle all outputs 0 and state IDLE; a new start then completes with pass=1.
6. SETTLE=0 → one vector per cycle; done 16 edges after start; table_out=16'hAC3C.
